// File: rtl/tqvp_rejunity_vga_copper_pkg.sv
// Shared definitions for the VGA copper: register-port write encodings, VGA register map,
// sequencer state encoding and the layout of one command-list entry.
package tqvp_rejunity_vga_copper_pkg;

  localparam logic [1:0] WR_NONE = 2'b11;
  localparam logic [1:0] WR_32   = 2'b10;

  localparam logic [5:0] REG_BG         = 6'h30;
  localparam logic [5:0] REG_FG         = 6'h31;
  localparam logic [5:0] REG_F2         = 6'h32;
  localparam logic [5:0] REG_F3         = 6'h33;
  localparam logic [5:0] REG_STRIDE     = 6'h34;
  localparam logic [5:0] REG_PIXEL_SIZE = 6'h35;
  localparam logic [5:0] REG_MODE       = 6'h36;

  localparam logic [9:0] COPPER_END_Y = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } copper_state_e;

  typedef struct packed {
    logic [9:0]  y;
    logic [5:0]  addr;
    logic [15:0] value;
  } copper_entry_t;

endpackage

// File: rtl/tqvp_rejunity_vga_copper_list_regs.sv
// Command list storage: ENTRIES x 32-bit flops, one write port, one asynchronous read port.
// Reset marks every entry as end-of-list so an unprogrammed list finishes immediately.
module tqvp_rejunity_vga_copper_list_regs
  import tqvp_rejunity_vga_copper_pkg::*;
#(
  parameter int         ENTRIES = 8,
  parameter int         IDX_W   = 3,
  parameter logic [9:0] END_Y   = COPPER_END_Y
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= {END_Y, 22'd0};
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/tqvp_rejunity_vga_copper.sv
// Raster command sequencer: replays {scanline, register, value} commands into the VGA
// register port during horizontal blank, sharing that port with the CPU (CPU has priority).
module tqvp_rejunity_vga_copper
  import tqvp_rejunity_vga_copper_pkg::*;
#(
  parameter int         ENTRIES = 8,
  parameter int         IDX_W   = 3,
  parameter logic [9:0] END_Y   = COPPER_END_Y
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_ctrl,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_wdata,
  output logic [7:0]       status,
  input  logic [9:0]       vga_y,
  input  logic             vga_blank,
  input  logic             vga_vsync,
  input  logic [1:0]       cpu_write_n,
  input  logic [5:0]       cpu_address,
  input  logic [31:0]      cpu_data,
  output logic [1:0]       reg_write_n,
  output logic [5:0]       reg_address,
  output logic [31:0]      reg_data,
  output logic             irq
);

  copper_state_e    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic             vsync_q;

  logic [31:0]   entry_word;
  copper_entry_t entry;
  logic          cpu_busy;
  logic          vsync_rise;
  logic          copper_wr;
  logic          last_entry;
  logic [2:0]    ptr_stat;

  tqvp_rejunity_vga_copper_list_regs #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .END_Y   (END_Y)
  ) u_list (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_we & ~cfg_ctrl),
    .widx_i  (cfg_idx),
    .wdata_i (cfg_wdata),
    .ridx_i  (ptr_q),
    .rdata_o (entry_word)
  );

  assign entry      = entry_word;
  assign cpu_busy   = (cpu_write_n != WR_NONE);
  assign vsync_rise = vga_vsync & ~vsync_q;
  assign last_entry = (ptr_q == IDX_W'(ENTRIES - 1));
  // A pending write only reaches the port while blank holds and the CPU is idle.
  assign copper_wr  = (state_q == ST_ISSUE) && vga_blank && !cpu_busy;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    irq_d    = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (entry.y == END_Y) begin
          state_d = ST_DONE;
          irq_d   = irq_en_q;
        end else if (vga_blank && !vga_vsync && (entry.y <= vga_y)) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!vga_blank) begin
          state_d = ST_WAIT;
        end else if (!cpu_busy) begin
          ptr_d = ptr_q + 1'b1;
          if (last_entry) begin
            state_d = ST_DONE;
            irq_d   = irq_en_q;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      default: ;
    endcase

    // Frame restart overrides list progress; the write driven this cycle still completes.
    if ((state_q != ST_IDLE) && vsync_rise) begin
      state_d = ST_WAIT;
      ptr_d   = '0;
      irq_d   = 1'b0;
    end

    if (cfg_we && cfg_ctrl) begin
      enable_d = cfg_wdata[0];
      irq_en_d = cfg_wdata[1];
      if (!cfg_wdata[0]) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        irq_d   = 1'b0;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_WAIT;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      vsync_q  <= vga_vsync;
    end
  end

  always_comb begin
    reg_write_n = WR_NONE;
    reg_address = 6'd0;
    reg_data    = 32'd0;
    if (cpu_busy) begin
      reg_write_n = cpu_write_n;
      reg_address = cpu_address;
      reg_data    = cpu_data;
    end else if (copper_wr) begin
      reg_write_n = WR_32;
      reg_address = entry.addr;
      reg_data    = {16'd0, entry.value};
    end
  end

  generate
    if (IDX_W >= 3) begin : g_ptr_wide
      assign ptr_stat = ptr_q[2:0];
    end else begin : g_ptr_narrow
      assign ptr_stat = {{(3 - IDX_W){1'b0}}, ptr_q};
    end
  endgenerate

  assign status = {enable_q, irq_en_q, state_q, 1'b0, ptr_stat};
  assign irq    = irq_q;

endmodule

// File: tb/tb_tqvp_rejunity_vga_copper.sv
// Bench for the VGA copper: directed scenarios plus randomized lists and scanline sequences,
// checked against a list-walking reference model of which entries fire on which scanline.
module tb_tqvp_rejunity_vga_copper;
  import tqvp_rejunity_vga_copper_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_ctrl;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_wdata;
  logic [7:0]  status;
  logic [9:0]  vga_y;
  logic        vga_blank, vga_vsync;
  logic [1:0]  cpu_write_n;
  logic [5:0]  cpu_address;
  logic [31:0] cpu_data;
  logic [1:0]  reg_write_n;
  logic [5:0]  reg_address;
  logic [31:0] reg_data;
  logic        irq;

  tqvp_rejunity_vga_copper dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ctrl    (cfg_ctrl),
    .cfg_idx     (cfg_idx),
    .cfg_wdata   (cfg_wdata),
    .status      (status),
    .vga_y       (vga_y),
    .vga_blank   (vga_blank),
    .vga_vsync   (vga_vsync),
    .cpu_write_n (cpu_write_n),
    .cpu_address (cpu_address),
    .cpu_data    (cpu_data),
    .reg_write_n (reg_write_n),
    .reg_address (reg_address),
    .reg_data    (reg_data),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference copy of the list contents and the irq enable.
  logic [9:0]  m_y [N];
  logic [5:0]  m_a [N];
  logic [15:0] m_v [N];
  logic        m_irq_en;
  logic [5:0]  reg_tbl [7] = '{REG_BG, REG_FG, REG_F2, REG_F3, REG_STRIDE, REG_PIXEL_SIZE, REG_MODE};

  logic [37:0] exp_q [$];
  int          exp_y [$];

  // Monitor: every 32-bit write on the port, with the scanline and cycle it appeared on.
  logic        mon_en = 1'b0;
  logic [37:0] obs_q [$];
  int          obs_y [$];
  int          obs_cyc [$];
  int          irq_cnt = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en && !rst) begin
      if (reg_write_n == WR_32) begin
        obs_q.push_back({reg_address, reg_data});
        obs_y.push_back(int'(vga_y));
        obs_cyc.push_back(cyc);
      end
      if (irq) irq_cnt++;
    end
  end

  // Walk the list over the frame's scanlines: every entry whose Y is at or below the current
  // line fires in that line's blank, in index order; END or running off the list terminates.
  function automatic bit model_frame(input int lines[$]);
    int p;
    bit term;
    p = 0;
    exp_q.delete();
    exp_y.delete();
    term = (m_y[0] == COPPER_END_Y);
    foreach (lines[k]) begin
      while (!term && int'(m_y[p]) <= lines[k]) begin
        exp_q.push_back({m_a[p], 16'd0, m_v[p]});
        exp_y.push_back(lines[k]);
        p++;
        if (p == N) term = 1'b1;
        else term = (m_y[p] == COPPER_END_Y);
      end
    end
    return term;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_entry(input int idx, input logic [9:0] y, input logic [5:0] a,
                           input logic [15:0] v);
    cfg_we = 1'b1; cfg_ctrl = 1'b0; cfg_idx = 3'(idx); cfg_wdata = {y, a, v};
    tick(1);
    cfg_we = 1'b0;
    m_y[idx] = y; m_a[idx] = a; m_v[idx] = v;
  endtask

  task automatic cfg_ctrl_w(input logic en, input logic ie);
    cfg_we = 1'b1; cfg_ctrl = 1'b1; cfg_wdata = {30'd0, ie, en};
    tick(1);
    cfg_we = 1'b0; cfg_ctrl = 1'b0;
    m_irq_en = ie;
  endtask

  task automatic vsync_pulse();
    vga_y = 10'd780; vga_blank = 1'b1; vga_vsync = 1'b1;
    tick(4);
    vga_y = 10'd0; vga_blank = 1'b0; vga_vsync = 1'b0;
    tick(2);
  endtask

  task automatic drive_line(input int y);
    vga_y = 10'(y); vga_blank = 1'b0;
    tick(6);
    vga_blank = 1'b1;
    tick(24);
    vga_blank = 1'b0;
  endtask

  task automatic run_frame(input int lines[$]);
    obs_q.delete(); obs_y.delete(); obs_cyc.delete();
    irq_cnt = 0;
    mon_en = 1'b1;
    vsync_pulse();
    foreach (lines[k]) drive_line(lines[k]);
    vga_y = 10'd0;
    tick(4);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    int lines[$];
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_y[i] = COPPER_END_Y;
    @(negedge clk);
    n_tests++;
    if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", status); end
    n_tests++;
    if ({reg_write_n, reg_address, reg_data, irq} !== {WR_NONE, 6'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_port: got wr=%b a=%h d=%h irq=%b want 11/00/0/0", reg_write_n, reg_address, reg_data, irq);
    end
    cpu_write_n = 2'b01; cpu_address = 6'h15; cpu_data = 32'hDEADBEEF;
    #1;
    n_tests++;
    if ({reg_write_n, reg_address, reg_data} !== {2'b01, 6'h15, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL cpu_passthrough: got wr=%b a=%h d=%h want 01/15/deadbeef", reg_write_n, reg_address, reg_data);
    end
    cpu_write_n = WR_NONE; cpu_address = 6'd0; cpu_data = 32'd0;
    @(posedge clk); #1;
    cfg_ctrl_w(1'b1, 1'b1);
    lines = '{5, 50, 100};
    run_frame(lines);
    n_tests++;
    if (obs_q.size() != 0 || irq_cnt != 1) begin
      n_fail++;
      $display("FAIL reset_list_end: got writes=%0d irq=%0d want 0/1", obs_q.size(), irq_cnt);
    end
  endtask

  task automatic test_single();
    int lines[$];
    cfg_entry(0, 10'd100, REG_BG, 16'h0003);
    cfg_entry(1, COPPER_END_Y, 6'd0, 16'd0);
    cfg_ctrl_w(1'b1, 1'b1);
    lines = '{50, 99, 100, 101, 150};
    for (int f = 0; f < 2; f++) begin
      run_frame(lines);
      n_tests++;
      if (obs_q.size() != 1) begin
        n_fail++; $display("FAIL single_count frame %0d: got %0d want 1", f, obs_q.size());
      end else begin
        n_tests++;
        if (obs_q[0] !== {REG_BG, 32'd3} || obs_y[0] != 100) begin
          n_fail++; $display("FAIL single_write: got %h@y%0d want %h@y100", obs_q[0], obs_y[0], {REG_BG, 32'd3});
        end
      end
      n_tests++;
      if (irq_cnt != 1) begin n_fail++; $display("FAIL single_irq: got %0d want 1", irq_cnt); end
    end
  endtask

  task automatic test_burst();
    int lines[$];
    cfg_entry(0, 10'd10, REG_FG, 16'h0011);
    cfg_entry(1, 10'd10, REG_F2, 16'h0022);
    cfg_entry(2, 10'd10, REG_F3, 16'h0033);
    cfg_entry(3, COPPER_END_Y, 6'd0, 16'd0);
    cfg_ctrl_w(1'b1, 1'b0);
    lines = '{5, 10, 20};
    run_frame(lines);
    n_tests++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL burst_count: got %0d want 3", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== {REG_FG, 32'h11} || obs_q[1] !== {REG_F2, 32'h22} || obs_q[2] !== {REG_F3, 32'h33}) begin
        n_fail++; $display("FAIL burst_order: got %h %h %h", obs_q[0], obs_q[1], obs_q[2]);
      end
      n_tests++;
      if (obs_cyc[1] - obs_cyc[0] != 2 || obs_cyc[2] - obs_cyc[1] != 2 || obs_y[2] != 10) begin
        n_fail++;
        $display("FAIL burst_spacing: got gaps %0d,%0d y=%0d want 2,2 y=10", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1], obs_y[2]);
      end
    end
    n_tests++;
    if (irq_cnt != 0) begin n_fail++; $display("FAIL burst_irq_masked: got %0d want 0", irq_cnt); end
  endtask

  task automatic test_cpu_priority();
    cfg_entry(0, 10'd10, REG_BG, 16'h1234);
    cfg_entry(1, COPPER_END_Y, 6'd0, 16'd0);
    cfg_ctrl_w(1'b1, 1'b0);
    vsync_pulse();
    vga_y = 10'd10;
    tick(2);
    vga_blank = 1'b1;
    tick(1);
    cpu_write_n = WR_32; cpu_address = REG_STRIDE; cpu_data = 32'hCAFE0001;
    @(negedge clk);
    n_tests++;
    if ({reg_write_n, reg_address, reg_data} !== {WR_32, REG_STRIDE, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL cpu_wins: got wr=%b a=%h d=%h want 10/%h/cafe0001", reg_write_n, reg_address, reg_data, REG_STRIDE);
    end
    @(posedge clk); #1;
    cpu_write_n = WR_NONE; cpu_address = 6'd0; cpu_data = 32'd0;
    @(negedge clk);
    n_tests++;
    if ({reg_write_n, reg_address, reg_data} !== {WR_32, REG_BG, 32'h1234}) begin
      n_fail++; $display("FAIL copper_after_cpu: got wr=%b a=%h d=%h want 10/%h/00001234", reg_write_n, reg_address, reg_data, REG_BG);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (reg_write_n !== WR_NONE || status[2:0] !== 3'd1) begin
      n_fail++; $display("FAIL copper_no_dup: got wr=%b ptr=%0d want 11 ptr=1", reg_write_n, status[2:0]);
    end
    vga_blank = 1'b0; vga_y = 10'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int lines[$];
    bit term;
    for (int i = 0; i < N; i++) cfg_entry(i, 10'(i), reg_tbl[i % 7], 16'($urandom));
    cfg_ctrl_w(1'b1, 1'b1);
    lines = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    term = model_frame(lines);
    for (int f = 0; f < 2; f++) begin
      run_frame(lines);
      n_tests++;
      if (obs_q.size() != N || !term) begin
        n_fail++; $display("FAIL wrap_count frame %0d: got %0d want %0d", f, obs_q.size(), N);
      end else begin
        for (int i = 0; i < N; i++) begin
          n_tests++;
          if (obs_q[i] !== exp_q[i] || obs_y[i] != exp_y[i]) begin
            n_fail++; $display("FAIL wrap_write %0d: got %h@y%0d want %h@y%0d", i, obs_q[i], obs_y[i], exp_q[i], exp_y[i]);
          end
        end
      end
      n_tests++;
      if (irq_cnt != 1) begin n_fail++; $display("FAIL wrap_irq: got %0d want 1", irq_cnt); end
      @(negedge clk);
      n_tests++;
      if (status !== 8'hF0) begin n_fail++; $display("FAIL wrap_status: got %h want f0", status); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_late_fire();
    cfg_entry(0, 10'd500, REG_MODE, 16'h0042);
    cfg_entry(1, COPPER_END_Y, 6'd0, 16'd0);
    cfg_ctrl_w(1'b1, 1'b1);
    obs_q.delete(); obs_y.delete(); obs_cyc.delete();
    irq_cnt = 0;
    mon_en = 1'b1;
    vsync_pulse();
    vga_y = 10'd200;
    tick(2);
    cfg_entry(0, 10'd50, REG_MODE, 16'h0042);
    tick(2);
    vga_blank = 1'b1;
    tick(24);
    vga_blank = 1'b0; vga_y = 10'd0;
    tick(4);
    mon_en = 1'b0;
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL late_count: got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== {REG_MODE, 32'h42} || obs_y[0] != 200) begin
        n_fail++; $display("FAIL late_write: got %h@y%0d want %h@y200", obs_q[0], obs_y[0], {REG_MODE, 32'h42});
      end
    end
    n_tests++;
    if (irq_cnt != 1) begin n_fail++; $display("FAIL late_irq: got %0d want 1", irq_cnt); end
  endtask

  task automatic test_disable_reset();
    int lines[$];
    for (int i = 0; i < 4; i++) cfg_entry(i, 10'd10, reg_tbl[i + 1], 16'(i + 1));
    cfg_entry(4, COPPER_END_Y, 6'd0, 16'd0);
    cfg_ctrl_w(1'b1, 1'b1);
    vsync_pulse();
    vga_y = 10'd10;
    tick(2);
    vga_blank = 1'b1;
    tick(3);
    cfg_ctrl_w(1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (status !== 8'h00 || reg_write_n !== WR_NONE) begin
      n_fail++; $display("FAIL disable_idle: got status=%h wr=%b want 00/11", status, reg_write_n);
    end
    @(posedge clk); #1;
    cfg_ctrl_w(1'b1, 1'b0);
    tick(1);
    @(negedge clk);
    n_tests++;
    if (reg_write_n !== WR_32 || reg_address !== REG_FG) begin
      n_fail++; $display("FAIL reenable_issue: got wr=%b a=%h want 10/%h", reg_write_n, reg_address, REG_FG);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (reg_write_n !== WR_NONE || status !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_issue: got wr=%b status=%h irq=%b want 11/00/0", reg_write_n, status, irq);
    end
    rst = 1'b0; vga_blank = 1'b0; vga_y = 10'd0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) m_y[i] = COPPER_END_Y;
    cfg_ctrl_w(1'b1, 1'b1);
    lines = '{10, 20};
    run_frame(lines);
    n_tests++;
    if (obs_q.size() != 0 || irq_cnt != 1) begin
      n_fail++; $display("FAIL reset_refill: got writes=%0d irq=%0d want 0/1", obs_q.size(), irq_cnt);
    end
  endtask

  task automatic test_random();
    int lines[$];
    bit term;
    int y;
    logic [9:0] ry;
    for (int f = 0; f < 12; f++) begin
      if (f % 3 == 0) begin
        for (int i = 0; i < N; i++) begin
          ry = ($urandom_range(0, 4) == 0) ? COPPER_END_Y : 10'($urandom_range(0, 300));
          cfg_entry(i, ry, reg_tbl[$urandom_range(0, 6)], 16'($urandom));
        end
        cfg_ctrl_w(1'b1, 1'($urandom_range(0, 1)));
      end
      lines.delete();
      y = $urandom_range(0, 20);
      for (int l = 0; l < 10; l++) begin
        lines.push_back(y);
        y += $urandom_range(1, 40);
      end
      term = model_frame(lines);
      run_frame(lines);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL random_count frame %0d: got %0d want %0d", f, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (obs_q[i] !== exp_q[i] || obs_y[i] != exp_y[i]) begin
            n_fail++;
            $display("FAIL random_write frame %0d idx %0d: got %h@y%0d want %h@y%0d", f, i, obs_q[i], obs_y[i], exp_q[i], exp_y[i]);
          end
        end
      end
      n_tests++;
      if (irq_cnt != ((term && m_irq_en) ? 1 : 0)) begin
        n_fail++; $display("FAIL random_irq frame %0d: got %0d want %0d", f, irq_cnt, (term && m_irq_en) ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_ctrl = 1'b0; cfg_idx = 3'd0; cfg_wdata = 32'd0;
    vga_y = 10'd0; vga_blank = 1'b0; vga_vsync = 1'b0;
    cpu_write_n = WR_NONE; cpu_address = 6'd0; cpu_data = 32'd0;
    m_irq_en = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_cpu_priority();
    test_wrap();
    test_late_fire();
    test_disable_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
